mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
// - Parametrised multi-cycle successor of the single-cycle MIPS core: same ISA subset, word-addressed PC.
// - Executes one instruction over 3-5 states; uses external instruction/data memories with req/ready handshakes.
// - Sits between the testbench/top level and the instruction and data memory models.
// - Adds over the single-cycle core: reset, wait states, illegal-opcode halt, and a retire strobe.
// PARAMETERS
// - ADDR_W    16  width of imem_addr, dmem_addr and the PC; word addresses
// - RESET_PC  0   PC value loaded at reset
// - HALT_ILL  1   1: an illegal opcode/funct enters HALT; 0: treat it as a NOP and retire
// PORTS
// - clock       in   1       rising-edge clock
// - reset_n     in   1       asynchronous, active-low reset
// - imem_req    out  1       instruction fetch request
// - imem_addr   out  ADDR_W  fetch word address (equals the PC)
// - imem_ready  in   1       fetch complete; imem_rdata valid this cycle
// - imem_rdata  in   32      instruction word
// - dmem_req    out  1       data access request
// - dmem_we     out  1       1 = store, 0 = load
// - dmem_addr   out  ADDR_W  data word address = ALU result [ADDR_W-1:0]
// - dmem_wdata  out  32      store data (Rt contents)
// - dmem_ready  in   1       data access complete; dmem_rdata valid when dmem_we = 0
// - dmem_rdata  in   32      load data
// - retire      out  1       1-cycle pulse when an instruction completes
// - halted      out  1       high while in HALT
// - pc_out      out  ADDR_W  architectural PC, for debug
// BEHAVIOUR
// - Reset (async, reset_n = 0):
//   - State goes to FETCH and PC to RESET_PC.
//   - All 32 registers clear to 0.
//   - All req/we/retire/halted outputs are 0; address and data outputs are 0.
// - Reset mid-transaction: any outstanding request is abandoned; a later ready is ignored.
// - Handshake:
//   - req rises and is held with stable addr/we/wdata until the cycle ready = 1 is sampled.
//   - ready may arrive in the same cycle req rises (zero wait states). req drops in the next cycle.
//   - ready while req = 0 is ignored.
// - States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; HALT is terminal until reset.
//   - FETCH: assert imem_req. On imem_ready, latch IR and go to DECODE.
//   - DECODE: read Rs/Rt into A/B and form the sign-extended immediate.
//     - Illegal op with HALT_ILL = 1 -> HALT.
//   - EXEC: compute the ALU result. Branches and jumps resolve here and go to FETCH:
//     - beq/bne: taken -> PC = PC+1+sext(imm); not taken -> PC = PC+1.
//     - j: PC = instr[25:0] zero-extended/truncated to ADDR_W.
//     - Every branch/jump raises retire.
//   - MEM (lw/sw): assert dmem_req.
//     - sw on ready -> PC += 1, retire, FETCH.
//     - lw on ready -> latch MDR, go to WB.
//   - WB: write rd (R-type) or rt (addi/lui/lw); PC += 1; retire; FETCH.
// - Minimum latency in cycles (zero-wait memory): R/addi/lui 4, lw 5, sw 4, beq/bne/j 3.
// - ISA subset:
//   - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02.
//   - Opcodes: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, lui 0x0F.
// - Arithmetic rules:
//   - 32-bit wrap-around; overflow is ignored (no trap).
//   - sll/srl shift the CONTENTS of Rt by shamt; srl is logical.
//   - lui writes {imm, 16'h0}.
//   - PC arithmetic wraps modulo 2^ADDR_W.
// - Register $0 always reads 0; writes to it are discarded.
// - A register write and a read of the same register never coincide; no bypass is needed.
// - HALT: all req outputs are 0, halted = 1, retire never asserts, PC is frozen.
// STRUCTURE
// - Package mips_pkg holds:
//   - opcode and funct localparams;
//   - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
//   - the ALU-op enum.
// - Sub-module mips_regfile: 32x32, 2 async read ports, 1 sync write port, async active-low clear, $0 hardwired.
// - ALU, decode and FSM stay inline in this module.
// TESTING
// - Reset/idle: hold reset_n = 0 for 3 cycles -> imem_req = 0, pc_out = 0.
//   - Release -> imem_req = 1, imem_addr = 0 in the first cycle.
// - R-type with zero-wait memory:
//   - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1.
//   - Expect $3 = 2 and $4 = 1, with retire pulses at cycles 4, 8, 12 and 16.
// - Memory with wait states: imem_ready and dmem_ready delayed 3 cycles.
//   - sw $1,7($0) then lw $5,7($0) -> dmem_addr = 7, dmem_wdata = 5, $5 = 5.
//   - req stays stable while waiting; lw takes 11 cycles.
// - Branch/jump:
//   - beq taken at PC 4 with imm = -2 -> next fetch address 3.
//   - bne not taken -> next fetch address 5.
//   - j 0x20 -> next fetch address 0x20.
// - Shift/lui: lui $6,0x1234 -> $6 = 0x12340000; srl $7,$6,4 -> $7 = 0x01234000; addi $0,$0,9 -> $0 still reads 0.
// - Illegal opcode and async reset:
//   - Opcode 0x3F -> halted = 1 after DECODE; no further imem_req.
//   - Assert reset_n during a stalled MEM state -> dmem_req = 0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, states, ALU ops and decoder for the multi-cycle MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_t;

    typedef enum logic [2:0] {
        CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_ILLEGAL
    } iclass_t;

    typedef struct packed {
        iclass_t cls;
        alu_op_t alu_op;
        logic    use_imm;
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
        decode_t d;
        d.cls     = CL_ILLEGAL;
        d.alu_op  = ALU_ADD;
        d.use_imm = 1'b0;
        case (op)
            OP_RTYPE: begin
                d.cls = CL_ALU_R;
                case (funct)
                    FN_ADD:  d.alu_op = ALU_ADD;
                    FN_SUB:  d.alu_op = ALU_SUB;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_SRL:  d.alu_op = ALU_SRL;
                    default: d.cls    = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                d.cls     = CL_ALU_I;
                d.use_imm = 1'b1;
            end
            OP_LUI: begin
                d.cls     = CL_ALU_I;
                d.alu_op  = ALU_LUI;
                d.use_imm = 1'b1;
            end
            OP_LW: begin
                d.cls     = CL_LOAD;
                d.use_imm = 1'b1;
            end
            OP_SW: begin
                d.cls     = CL_STORE;
                d.use_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.cls    = CL_BRANCH;
                d.alu_op = ALU_SUB;
            end
            OP_J:    d.cls = CL_JUMP;
            default: d.cls = CL_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async reads, one sync write, $0 hardwired to zero
module mips_regfile (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'd0 : regs_q[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : regs_q[rd_addr1];

endmodule

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS subset core with req/ready instruction and data memories
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                HALT_ILL = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;

    decode_t           dec;
    logic [4:0]        rs, rt, rd, shamt;
    logic [31:0]       rf_rdata0, rf_rdata1, rf_wdata;
    logic [4:0]        rf_waddr;
    logic              rf_we;
    logic [31:0]       alu_b, alu_res;
    logic [ADDR_W-1:0] pc_inc, br_target;
    logic              br_taken;
    logic              fetch_req;

    assign dec   = decode_instr(ir_q[31:26], ir_q[5:0]);
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];

    mips_regfile u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_addr0 (rs),
        .rd_addr1 (rt),
        .rd_data0 (rf_rdata0),
        .rd_data1 (rf_rdata1),
        .wr_en    (rf_we),
        .wr_addr  (rf_waddr),
        .wr_data  (rf_wdata)
    );

    // Shifts act on Rt's contents; lui ignores A entirely.
    always_comb begin
        alu_b = dec.use_imm ? imm_q : b_q;
        case (dec.alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {31'd0, ($signed(a_q) < $signed(alu_b))};
            ALU_SLL: alu_res = b_q << shamt;
            ALU_SRL: alu_res = b_q >> shamt;
            ALU_LUI: alu_res = {imm_q[15:0], 16'h0000};
            default: alu_res = a_q + alu_b;
        endcase
    end

    // Opcode bit 0 separates bne (0x05) from beq (0x04).
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign br_target = pc_inc + ADDR_W'($signed(imm_q[15:0]));
    assign br_taken  = (a_q == b_q) ^ ir_q[26];

    assign rf_waddr = (dec.cls == CL_ALU_R) ? rd : rt;
    assign rf_wdata = (dec.cls == CL_LOAD) ? mdr_q : alu_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        fetch_req = 1'b0;
        dmem_req  = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d   = rf_rdata0;
                b_d   = rf_rdata1;
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
                if (HALT_ILL && (dec.cls == CL_ILLEGAL)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_d = alu_res;
                case (dec.cls)
                    CL_ALU_R, CL_ALU_I: state_d = ST_WB;
                    CL_LOAD, CL_STORE:  state_d = ST_MEM;
                    CL_BRANCH: begin
                        pc_d    = br_taken ? br_target : pc_inc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pc_d    = ADDR_W'(ir_q[25:0]);
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        // Illegal instruction retired as a NOP when halting is disabled.
                        pc_d    = pc_inc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (dec.cls == CL_STORE) begin
                        pc_d    = pc_inc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_inc;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // State already sits in FETCH during reset, so the fetch request is masked until release.
    assign imem_req   = fetch_req & reset_n;
    assign imem_addr  = imem_req ? pc_q : '0;
    assign dmem_we    = dmem_req & (dec.cls == CL_STORE);
    assign dmem_addr  = dmem_req ? ADDR_W'(alu_q) : '0;
    assign dmem_wdata = dmem_we ? b_q : 32'd0;
    assign halted     = (state_q == ST_HALT);
    assign pc_out     = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - table-driven program runs plus reset, halt and mid-access reset sequences
module tb_mips_multicycle_core;

    logic        clock;
    logic        reset_n;
    logic        imem_req, imem_ready;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        retire, halted;
    logic [15:0] pc_out;

    mips_multicycle_core #(.ADDR_W(16), .RESET_PC(16'h0000), .HALT_ILL(1'b1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted),
        .pc_out     (pc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [7:0]  icnt, dcnt;
    int          iw, dw;

    assign imem_ready = imem_req && (int'(icnt) >= iw);
    assign dmem_ready = dmem_req && (int'(dcnt) >= dw);
    assign imem_rdata = imem[imem_addr[5:0]];
    assign dmem_rdata = dmem[dmem_addr[5:0]];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            icnt <= 8'd0;
            dcnt <= 8'd0;
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 8'd1 : 8'd0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 8'd1 : 8'd0;
            if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    typedef struct packed {
        logic [3:0]  prog_id;
        logic [7:0]  n_ret;
        logic [3:0]  iw;
        logic [3:0]  dw;
        logic [15:0] exp_addr;
        logic [31:0] exp_data;
        logic [15:0] exp_pc;
        logic [7:0]  exp_cyc;
    } vec_t;

    function automatic vec_t mk(input int p, input int n, input int wi, input int wd,
                                input int a, input logic [31:0] d, input int pc, input int cyc);
        vec_t v;
        v.prog_id = 4'(p); v.n_ret = 8'(n); v.iw = 4'(wi); v.dw = 4'(wd);
        v.exp_addr = 16'(a); v.exp_data = d; v.exp_pc = 16'(pc); v.exp_cyc = 8'(cyc);
        return v;
    endfunction

    logic [31:0] progs [8][10];
    vec_t        vecs [14];

    task automatic load_prog(input int id);
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        for (int i = 0; i < 10; i++) imem[i] = progs[id][i];
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] st_addr, h_iaddr, h_daddr;
        logic [31:0] st_data, h_dwdata;
        int ret_cnt, last_cyc, stable_err;
        bit ihold, dhold;
        load_prog(int'(v.prog_id));
        iw = int'(v.iw);
        dw = int'(v.dw);
        do_reset();
        st_addr = 16'hDEAD; st_data = 32'hDEADBEEF;
        ret_cnt = 0; last_cyc = 0; stable_err = 0; ihold = 0; dhold = 0;
        h_iaddr = '0; h_daddr = '0; h_dwdata = '0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int c = 1; c <= 400 && ret_cnt < int'(v.n_ret); c++) begin
            @(negedge clock);
            if (imem_req) begin
                if (ihold && imem_addr != h_iaddr) stable_err++;
                ihold = !imem_ready; h_iaddr = imem_addr;
            end
            if (dmem_req) begin
                if (dhold && (dmem_addr != h_daddr || dmem_wdata != h_dwdata)) stable_err++;
                dhold = !dmem_ready; h_daddr = dmem_addr; h_dwdata = dmem_wdata;
                if (dmem_ready && dmem_we) begin
                    st_addr = dmem_addr; st_data = dmem_wdata;
                end
            end
            if (retire) begin
                ret_cnt++; last_cyc = c;
            end
        end
        @(negedge clock);
        chk($sformatf("v%0d_store_addr", idx), 32'(st_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d_store_data", idx), st_data, v.exp_data);
        chk($sformatf("v%0d_pc", idx), 32'(pc_out), 32'(v.exp_pc));
        chk($sformatf("v%0d_last_retire_cycle", idx), 32'(last_cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d_req_stable_errs", idx), 32'(stable_err), 32'd0);
    endtask

    initial begin
        int ret_cyc [4];
        int rc, halt_cyc, req_after, rets;

        reset_n = 1'b0;
        iw = 0; dw = 0;
        for (int p = 0; p < 8; p++) for (int i = 0; i < 10; i++) progs[p][i] = 32'd0;

        progs[0][0] = enc_i(8, 0, 1, 5);
        progs[0][1] = enc_i(8, 0, 2, -3);
        progs[0][2] = enc_r(1, 2, 3, 0, 32'h20);
        progs[0][3] = enc_r(2, 1, 4, 0, 32'h2A);
        progs[0][4] = enc_i(32'h2B, 0, 3, 0);
        progs[0][5] = enc_i(32'h2B, 0, 4, 1);

        progs[1][0] = enc_i(8, 0, 1, 5);
        progs[1][1] = enc_i(32'h2B, 0, 1, 7);
        progs[1][2] = enc_i(32'h23, 0, 5, 7);
        progs[1][3] = enc_i(32'h2B, 0, 5, 8);

        progs[2][0] = enc_i(8, 0, 1, 5);
        progs[2][1] = enc_i(8, 0, 2, 5);
        progs[2][2] = enc_i(8, 0, 3, 1);
        progs[2][3] = enc_i(32'h2B, 0, 3, 9);
        progs[2][4] = enc_i(4, 1, 2, -2);

        progs[3][0] = enc_i(8, 0, 1, 5);
        progs[3][1] = enc_i(8, 0, 2, 5);
        progs[3][2] = enc_i(8, 0, 3, 7);
        progs[3][3] = enc_i(32'h2B, 0, 3, 2);
        progs[3][4] = enc_i(5, 1, 2, -2);

        progs[4][0] = enc_i(8, 0, 1, -1);
        progs[4][1] = enc_i(32'h2B, 0, 1, 3);
        progs[4][2] = enc_j(32'h20);

        progs[5][0] = enc_i(32'h0F, 0, 6, 32'h1234);
        progs[5][1] = enc_r(0, 6, 7, 4, 32'h02);
        progs[5][2] = enc_i(8, 0, 0, 9);
        progs[5][3] = enc_i(32'h2B, 0, 7, 4);
        progs[5][4] = enc_i(32'h2B, 0, 0, 5);

        progs[6][0] = enc_i(32'h0F, 0, 6, 32'h1234);
        progs[6][1] = enc_i(32'h2B, 0, 6, 6);

        progs[7][0] = enc_i(8, 0, 1, 12);
        progs[7][1] = enc_i(8, 0, 2, 10);
        progs[7][2] = enc_r(2, 1, 3, 0, 32'h22);
        progs[7][3] = enc_r(1, 2, 4, 0, 32'h24);
        progs[7][4] = enc_r(1, 2, 5, 0, 32'h25);
        progs[7][5] = enc_r(4, 5, 7, 0, 32'h20);
        progs[7][6] = enc_r(0, 3, 6, 4, 32'h00);
        progs[7][7] = enc_i(32'h2B, 0, 6, 10);
        progs[7][8] = enc_i(32'h2B, 0, 7, 11);

        //             prog n_ret iw dw addr  data          pc    cycle
        vecs[0]  = mk(0,   5,    0, 0, 0,    32'd2,        5,    20);
        vecs[1]  = mk(0,   6,    0, 0, 1,    32'd1,        6,    24);
        vecs[2]  = mk(1,   2,    3, 3, 7,    32'd5,        2,    17);
        vecs[3]  = mk(1,   4,    3, 3, 8,    32'd5,        4,    38);
        vecs[4]  = mk(1,   4,    0, 0, 8,    32'd5,        4,    17);
        vecs[5]  = mk(2,   5,    0, 0, 9,    32'd1,        3,    19);
        vecs[6]  = mk(3,   5,    0, 0, 2,    32'd7,        5,    19);
        vecs[7]  = mk(4,   3,    0, 0, 3,    32'hFFFFFFFF, 32,   11);
        vecs[8]  = mk(5,   4,    0, 0, 4,    32'h01234000, 4,    16);
        vecs[9]  = mk(5,   5,    0, 0, 5,    32'd0,        5,    20);
        vecs[10] = mk(6,   2,    0, 0, 6,    32'h12340000, 2,    8);
        vecs[11] = mk(7,   8,    0, 0, 10,   32'hFFFFFFE0, 8,    32);
        vecs[12] = mk(7,   9,    0, 0, 11,   32'd22,       9,    36);
        vecs[13] = mk(1,   3,    3, 3, 7,    32'd5,        3,    28);

        // Reset/idle and first-cycle fetch, then retire timing of the R-type program.
        load_prog(0);
        do_reset();
        @(negedge clock);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("rel_imem_req", 32'(imem_req), 32'd1);
        chk("rel_imem_addr", 32'(imem_addr), 32'd0);
        rc = 0;
        for (int k = 0; k < 4; k++) ret_cyc[k] = 0;
        for (int c = 1; c <= 40 && rc < 4; c++) begin
            @(negedge clock);
            if (retire) begin
                ret_cyc[rc] = c; rc++;
            end
        end
        for (int k = 0; k < 4; k++) chk($sformatf("rtype_retire_cycle%0d", k), 32'(ret_cyc[k]), 32'(4 * (k + 1)));

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Illegal opcode halts after DECODE and stays quiet.
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        imem[0] = 32'hFC000000;
        iw = 0; dw = 0;
        do_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        halt_cyc = 0; req_after = 0; rets = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            if (halted && halt_cyc == 0) halt_cyc = c;
            if (imem_req && c > 1) req_after++;
            if (retire) rets++;
        end
        chk("ill_halt_cycle", 32'(halt_cyc), 32'd3);
        chk("ill_req_after", 32'(req_after), 32'd0);
        chk("ill_retires", 32'(rets), 32'd0);
        chk("ill_pc_frozen", 32'(pc_out), 32'd0);
        chk("ill_halted", 32'(halted), 32'd1);

        // Reset asserted while a store is stalled in MEM.
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        imem[0] = enc_i(32'h2B, 0, 0, 3);
        iw = 0; dw = 20;
        do_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("midrst_dmem_req_before", 32'(dmem_req), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_dmem_req_after", 32'(dmem_req), 32'd0);
        chk("midrst_imem_req_in_reset", 32'(imem_req), 32'd0);
        dw = 0;
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("midrst_refetch_req", 32'(imem_req), 32'd1);
        chk("midrst_refetch_addr", 32'(imem_addr), 32'd0);
        chk("midrst_no_dmem_req", 32'(dmem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
